// File: rtl/m_unit_ctrl.sv
// m_unit_ctrl: RV32M sequencing controller for the shared M-extension ALU (multiply, 32-step restoring divide, sign fix-up).
// Ports: clk/resetn (async active-low); req_valid/req_ready/req_funct3/req_a/req_b issue side;
//   resp_valid/resp_ready/resp_result response side; mux_div_rem, alu_R/D/Z, alu_mult_a/b drive m_alu;
//   alu_sub_neg/alu_sub_res/alu_div_rem/alu_div_rem_neg/alu_product come back from m_alu.
// Optional: define M_DIV_EARLY_OUT_EN to answer divide-by-zero and signed overflow straight from IDLE.
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif
`ifndef MUX_DIV_REM_Z
`define MUX_DIV_REM_Z 1'b0
`endif
`ifndef MUX_DIV_REM_R
`define MUX_DIV_REM_R 1'b1
`endif
module m_unit_ctrl #(
  parameter int XLEN = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [2:0]                     req_funct3,
  input  logic [31:0]                    req_a,
  input  logic [31:0]                    req_b,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_result,
  output logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
  output logic [31:0]                    alu_R,
  output logic [62:0]                    alu_D,
  output logic [31:0]                    alu_Z,
  output logic [32:0]                    alu_mult_a,
  output logic [32:0]                    alu_mult_b,
  input  logic                           alu_sub_neg,
  input  logic [31:0]                    alu_sub_res,
  input  logic [31:0]                    alu_div_rem,
  input  logic [31:0]                    alu_div_rem_neg,
  input  logic [65:0]                    alu_product
);
  if (XLEN != 32) begin : g_xlen_check
    $error("m_unit_ctrl supports XLEN=32 only");
  end
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  state_t state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d, b_zero_q, b_zero_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] r_q, r_d, z_q, z_d, res_q, res_d;
  logic [62:0] d_q, d_d;
  logic [32:0] ma_q, ma_d, mb_q, mb_d;
  logic        is_signed, early, neg;
  logic [31:0] abs_a, abs_b, early_res;
  logic        unused_product;
  assign unused_product = ^alu_product[65:64];
  assign is_signed = req_funct3[2] && !req_funct3[0];
  assign abs_a = (is_signed && req_a[31]) ? -req_a : req_a;
  assign abs_b = (is_signed && req_b[31]) ? -req_b : req_b;
`ifdef M_DIV_EARLY_OUT_EN
  assign early = req_funct3[2] && (req_b == '0 || (is_signed && req_a == 32'h8000_0000 && req_b == '1));
`else
  assign early = 1'b0;
`endif
  // Boundary answers the full divide would produce anyway: b=0 or signed overflow.
  assign early_res = req_funct3[1] ? ((req_b == '0) ? req_a : 32'd0)
                                   : ((req_b == '0) ? 32'hFFFF_FFFF : 32'h8000_0000);
  // Remainder takes the dividend sign; quotient flips on differing signs unless b was zero.
  assign neg = funct3_q[1] ? sign_a_q : (sign_a_q ^ sign_b_q) && !b_zero_q;
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    d_d      = d_q;
    z_d      = z_q;
    res_d    = res_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        funct3_d = req_funct3;
        sign_a_d = is_signed && req_a[31];
        sign_b_d = is_signed && req_b[31];
        b_zero_d = req_b == '0;
        if (req_funct3[2]) begin
          r_d     = abs_a;
          d_d     = {abs_b, 31'd0};
          z_d     = '0;
          cnt_d   = 5'd31;
          res_d   = early ? early_res : res_q;
          state_d = early ? S_DONE : S_DIV;
        end else begin
          ma_d    = {req_funct3[1:0] != 2'b11 && req_a[31], req_a};
          mb_d    = {!req_funct3[1] && req_b[31], req_b};
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        res_d   = (funct3_q[1:0] == 2'b00) ? alu_product[31:0] : alu_product[63:32];
        state_d = S_DONE;
      end
      S_DIV: begin
        r_d     = alu_sub_neg ? r_q : alu_sub_res;
        z_d     = {z_q[30:0], !alu_sub_neg};
        d_d     = d_q >> 1;
        cnt_d   = cnt_q - 5'd1;
        state_d = (cnt_q == 5'd0) ? S_FIX : S_DIV;
      end
      S_FIX: begin
        res_d   = neg ? alu_div_rem_neg : alu_div_rem;
        state_d = S_DONE;
      end
      S_DONE: state_d = resp_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      cnt_q    <= '0;
      r_q      <= '0;
      d_q      <= '0;
      z_q      <= '0;
      res_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      d_q      <= d_d;
      z_q      <= z_d;
      res_q    <= res_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
    end
  end
  assign req_ready   = state_q == S_IDLE;
  assign resp_valid  = state_q == S_DONE;
  assign resp_result = res_q;
  assign mux_div_rem = (state_q == S_FIX && funct3_q[1]) ? `MUX_DIV_REM_R : `MUX_DIV_REM_Z;
  assign alu_R       = r_q;
  assign alu_D       = d_q;
  assign alu_Z       = z_q;
  assign alu_mult_a  = ma_q;
  assign alu_mult_b  = mb_q;
endmodule
